// File: rtl/s2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : s2_pkg
// Description : Shared FSM state type and default sizes for the S2 receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package s2_pkg;

    localparam int C_ADDR_W  = 3;
    localparam int C_DATA_W  = 18;
    localparam int C_PKT_W   = C_ADDR_W + C_DATA_W;
    localparam int C_NUM_PKT = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } s2_state_t;

endpackage : s2_pkg
`default_nettype wire

// File: rtl/s2_deser.sv
`default_nettype none
// ============================================================================
// Module      : s2_deser
// Description : Serial-to-parallel shifter with a saturating bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module s2_deser
    import s2_pkg::*;
#(
    parameter int W = C_PKT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sen,
    input  logic         sd,
    input  logic         clr,
    output logic [W-1:0] word,
    output logic [4:0]   count
);

    // clr restarts framing: a bit arriving with clr becomes the first bit of a new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            word  <= '0;
            count <= '0;
        end else if (clr) begin
            if (!sen) begin
                word  <= {{(W-1){1'b0}}, sd};
                count <= 5'd1;
            end else begin
                word  <= '0;
                count <= '0;
            end
        end else if (!sen) begin
            word <= {word[W-2:0], sd};
            if (count != 5'd31) begin
                count <= count + 5'd1;
            end
        end
    end

endmodule : s2_deser
`default_nettype wire

// File: rtl/s2_receiver.sv
`default_nettype none
// ============================================================================
// Module      : s2_receiver
// Description : Receives framed serial packets and writes them into RB2.
// Revision    : 1.0 - initial release
// ============================================================================
module s2_receiver
    import s2_pkg::*;
#(
    parameter int ADDR_W  = C_ADDR_W,
    parameter int DATA_W  = C_DATA_W,
    parameter int NUM_PKT = C_NUM_PKT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sen,
    input  logic              sd,
    output logic              RB2_RW,
    output logic [ADDR_W-1:0] RB2_A,
    output logic [DATA_W-1:0] RB2_D,
    input  logic [DATA_W-1:0] RB2_Q,
    output logic              S2_done
);

    localparam int             PKT_W  = ADDR_W + DATA_W;
    localparam int             CNT_W  = $clog2(NUM_PKT + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_PKT - 1);
    localparam logic [4:0]     C_FULL = 5'(PKT_W);

    s2_state_t        r_state;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic [PKT_W-1:0] w_word;
    logic [4:0]       w_count;
    logic             w_clr;
    logic             w_sen_eff;
    logic             w_unused_q;

    assign w_unused_q = ^RB2_Q;

    // Outside RECV every sampled bit starts a new frame; DONE masks the line entirely.
    assign w_clr     = (r_state != S_RECV);
    assign w_sen_eff = sen | (r_state == S_DONE);

    s2_deser #(
        .W (PKT_W)
    ) u_deser (
        .clk   (clk),
        .rst   (rst),
        .sen   (w_sen_eff),
        .sd    (sd),
        .clr   (w_clr),
        .word  (w_word),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pkt_cnt <= '0;
            RB2_RW    <= 1'b1;
            RB2_A     <= '0;
            RB2_D     <= '0;
            S2_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    RB2_RW <= 1'b1;
                    if (!sen) begin
                        r_state <= S_RECV;
                    end
                end
                S_RECV: begin
                    RB2_RW <= 1'b1;
                    if (sen) begin
                        if (w_count == C_FULL) begin
                            r_state <= S_WRITE;
                            RB2_RW  <= 1'b0;
                            RB2_A   <= w_word[PKT_W-1 -: ADDR_W];
                            RB2_D   <= w_word[DATA_W-1:0];
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_WRITE: begin
                    RB2_RW    <= 1'b1;
                    r_pkt_cnt <= r_pkt_cnt + 1'b1;
                    if (r_pkt_cnt == C_LAST) begin
                        r_state <= S_DONE;
                        S2_done <= 1'b1;
                    end else if (!sen) begin
                        r_state <= S_RECV;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    RB2_RW  <= 1'b1;
                    S2_done <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    RB2_RW  <= 1'b1;
                end
            endcase
        end
    end

endmodule : s2_receiver
`default_nettype wire

// File: tb/tb_s2_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_s2_receiver
// Description : Self-checking bench for s2_receiver with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s2_receiver;

    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 18;
    localparam int NUM_PKT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sen = 1'b1;
    logic              sd  = 1'b0;
    logic              RB2_RW;
    logic [ADDR_W-1:0] RB2_A;
    logic [DATA_W-1:0] RB2_D;
    logic [DATA_W-1:0] RB2_Q = '0;
    logic              S2_done;

    s2_receiver #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NUM_PKT (NUM_PKT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .sen     (sen),
        .sd      (sd),
        .RB2_RW  (RB2_RW),
        .RB2_A   (RB2_A),
        .RB2_D   (RB2_D),
        .RB2_Q   (RB2_Q),
        .S2_done (S2_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                c;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_wr     = 0;
    int   m_good   = 0;
    bit   m_done   = 1'b0;
    int   done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Observed writes are matched in order against the model's expected writes.
    always @(negedge clk) begin
        if (RB2_RW === 1'b0) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(RB2_A), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_cycle", 32'(cyc), 32'(e.c));
                check("wr_addr", 32'(RB2_A), 32'(e.a));
                check("wr_data", 32'(RB2_D), 32'(e.d));
            end
        end
        if (!rst) begin
            check("done_flag", 32'(S2_done), 32'(m_done && (cyc >= done_cyc)));
        end
    end

    task automatic drive(input logic s, input logic d);
        @(posedge clk);
        #1;
        sen = s;
        sd  = d;
    endtask

    // Frame-level model: only exact-length frames before completion produce a write.
    task automatic model_end(input int nbits, input logic [20:0] pl);
        exp_t e;
        if (nbits == ADDR_W + DATA_W && !m_done) begin
            e.a = pl[20:18];
            e.d = pl[17:0];
            e.c = cyc + 1;
            exp_q.push_back(e);
            m_good++;
            if (m_good == NUM_PKT) begin
                m_done   = 1'b1;
                done_cyc = cyc + 2;
            end
        end
    endtask

    task automatic send_frame(input int nbits, input logic [20:0] pl, input int gap);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, (i < 21) ? pl[20-i] : 1'($urandom));
        end
        if (gap > 0) begin
            drive(1'b1, 1'($urandom));
            model_end(nbits, pl);
            for (int g = 1; g < gap; g++) begin
                drive(1'b1, 1'($urandom));
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        sen = 1'($urandom);
        sd  = 1'($urandom);
        m_good = 0;
        m_done = 1'b0;
        @(posedge clk);
        #1;
        sen = 1'($urandom);
        sd  = 1'($urandom);
        @(negedge clk);
        check("rst_rw", 32'(RB2_RW), 32'd1);
        check("rst_addr", 32'(RB2_A), 32'd0);
        check("rst_data", 32'(RB2_D), 32'd0);
        check("rst_done", 32'(S2_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sen = 1'b1;
        sd  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'($urandom));
    endtask

    initial begin
        int w0;
        int r;
        int nb;
        logic [20:0] pl;

        do_reset();
        idle(2);

        // Single packet
        send_frame(21, {3'b101, 18'h2AAAA}, 3);
        check("single_not_done", 32'(S2_done), 32'd0);

        // Eight back-to-back packets, then traffic after completion
        do_reset();
        for (int a = 0; a < 8; a++) begin
            pl = {3'(a), 18'(a * 18'h01111)};
            send_frame(21, pl, 1);
        end
        idle(2);
        check("eight_done", 32'(S2_done), 32'd1);
        w0 = n_wr;
        for (int k = 0; k < 3; k++) send_frame(21, 21'($urandom), 1);
        idle(2);
        check("after_done_writes", 32'(n_wr - w0), 32'd0);
        check("after_done_flag", 32'(S2_done), 32'd1);

        // Short frame followed by a good one
        do_reset();
        w0 = n_wr;
        send_frame(20, 21'($urandom), 2);
        send_frame(21, {3'd2, 18'h1F00D}, 2);
        idle(2);
        check("short_then_good_writes", 32'(n_wr - w0), 32'd1);
        check("short_then_good_count", 32'(m_good), 32'd1);

        // Reset mid-packet, then a full packet
        w0 = n_wr;
        send_frame(10, 21'($urandom), 0);
        do_reset();
        send_frame(21, {3'd6, 18'h0BEEF}, 2);
        idle(2);
        check("reset_abort_writes", 32'(n_wr - w0), 32'd1);

        // Saturation: 53 bits would alias to 21 in a wrapping 5-bit counter
        w0 = n_wr;
        send_frame(53, 21'($urandom), 2);
        send_frame(22, 21'($urandom), 1);
        idle(2);
        check("overlong_writes", 32'(n_wr - w0), 32'd0);

        // Randomised traffic with occasional aborting resets
        do_reset();
        for (int f = 0; f < 70; f++) begin
            r = $urandom_range(0, 9);
            case (r)
                0:       nb = 20;
                1:       nb = 22;
                2:       nb = 53;
                3:       nb = $urandom_range(1, 19);
                4:       nb = 40;
                default: nb = 21;
            endcase
            pl = 21'($urandom);
            if ($urandom_range(0, 11) == 0) begin
                send_frame(nb, pl, 0);
                do_reset();
            end else begin
                send_frame(nb, pl, $urandom_range(1, 3));
                if (f % 15 == 14) do_reset();
            end
        end
        idle(4);
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_s2_receiver
`default_nettype wire
